// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the default bit-period
// derivation used by both the receiver and the transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_rx_state_t;

    // Bit time minus one in clk cycles, truncated to the 16-bit counter width.
    function automatic logic [15:0] default_bit_period(input int unsigned clk_freq,
                                                       input int unsigned baud_rate);
        return 16'((clk_freq / baud_rate) - 1);
    endfunction

endpackage

// File: rtl/uart_sync_2ff.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle-high level.
module uart_sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic sync_p0;
    logic sync_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
        end else begin
            sync_p0 <= d;
            sync_p1 <= sync_p0;
        end
    end

    assign q = sync_p1;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB-first, one parity bit, one stop bit, mid-bit sampling
// with a runtime-programmable bit period and sticky error reporting.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_RATE = 115200,
    parameter int unsigned CLK_FREQ  = 50000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_bit_period_i,
    input  logic [15:0] bit_period_i,
    input  logic        parity_type_i,
    input  logic        uart_rxd,
    input  logic        rx_read_i,
    input  logic        clear_err_i,
    output logic [7:0]  uart_rx_data,
    output logic        uart_rx_valid,
    output logic        uart_rx_busy,
    output logic        parity_err_o,
    output logic        frame_err_o,
    output logic        overrun_o
);

    localparam logic [15:0] P_DEFAULT = default_bit_period(CLK_FREQ, BAUD_RATE);

    uart_rx_state_t state_q, state_d;
    logic        rxd_s;
    logic        armed_q, armed_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [15:0] bit_period_q;
    logic        commit;
    logic        set_perr;
    logic        set_ferr;

    function automatic logic exp_parity(input logic [7:0] d, input logic odd_sel);
        return odd_sel ? ^d : ~^d;
    endfunction

    uart_sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (uart_rxd),
        .q   (rxd_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            armed_q       <= 1'b0;
            cnt_q         <= 16'd0;
            bit_idx_q     <= 3'd0;
            bit_period_q  <= P_DEFAULT;
            uart_rx_data  <= 8'h00;
            uart_rx_valid <= 1'b0;
            parity_err_o  <= 1'b0;
            frame_err_o   <= 1'b0;
            overrun_o     <= 1'b0;
        end else begin
            state_q       <= state_d;
            armed_q       <= armed_d;
            cnt_q         <= cnt_d;
            bit_idx_q     <= bit_idx_d;
            if (wr_bit_period_i)
                bit_period_q <= bit_period_i;
            if (commit)
                uart_rx_data <= shreg_q;
            // A commit coinciding with a read keeps the new byte and is not an overrun.
            uart_rx_valid <= commit | (uart_rx_valid & ~rx_read_i);
            parity_err_o  <= set_perr | (parity_err_o & ~clear_err_i);
            frame_err_o   <= set_ferr | (frame_err_o & ~clear_err_i);
            overrun_o     <= (commit & uart_rx_valid & ~rx_read_i) | (overrun_o & ~clear_err_i);
        end
    end

    // Shift register is fully rewritten before every use, so it carries no reset.
    always_ff @(posedge clk) begin
        shreg_q <= shreg_d;
    end

    always_comb begin
        state_d   = state_q;
        armed_d   = armed_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        commit    = 1'b0;
        set_perr  = 1'b0;
        set_ferr  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!armed_q) begin
                    if (rxd_s)
                        armed_d = 1'b1;
                end else if (!rxd_s) begin
                    cnt_d   = bit_period_q >> 1;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (cnt_q != 16'd0) begin
                    cnt_d = cnt_q - 16'd1;
                end else if (!rxd_s) begin
                    cnt_d     = bit_period_q;
                    bit_idx_d = 3'd0;
                    state_d   = ST_DATA;
                end else begin
                    state_d = ST_IDLE;
                    armed_d = 1'b0;
                end
            end
            ST_DATA: begin
                if (cnt_q != 16'd0) begin
                    cnt_d = cnt_q - 16'd1;
                end else begin
                    shreg_d   = {rxd_s, shreg_q[7:1]};
                    cnt_d     = bit_period_q;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7)
                        state_d = ST_PARITY;
                end
            end
            ST_PARITY: begin
                if (cnt_q != 16'd0) begin
                    cnt_d = cnt_q - 16'd1;
                end else begin
                    set_perr = (rxd_s != exp_parity(shreg_q, parity_type_i));
                    cnt_d    = bit_period_q;
                    state_d  = ST_STOP;
                end
            end
            ST_STOP: begin
                if (cnt_q != 16'd0) begin
                    cnt_d = cnt_q - 16'd1;
                end else begin
                    set_ferr = ~rxd_s;
                    commit   = 1'b1;
                    state_d  = ST_IDLE;
                    armed_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                armed_d = 1'b0;
            end
        endcase
    end

    assign uart_rx_busy = (state_q != ST_IDLE);

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter BAUD_RATE, default 115200, nominal line rate.
REQ-002 SHALL have parameter CLK_FREQ, default 50000000, clk frequency in Hz.
REQ-003 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port wr_bit_period_i  input  1  load bit_period_i into the bit-period register.
REQ-006 SHALL have port bit_period_i  input  16  bit time minus one, in clk cycles.
REQ-007 SHALL have port parity_type_i  input  1  parity select; expected parity = parity_type_i ? ^data : ~^data (matches the transmitter).
REQ-008 SHALL have port uart_rxd  input  1  asynchronous serial line, idle high.
REQ-009 SHALL have port rx_read_i  input  1  consumer acknowledge of held byte.
REQ-010 SHALL have port clear_err_i  input  1  clears sticky error flags.
REQ-011 SHALL have port uart_rx_data  output  8  last received byte.
REQ-012 SHALL have port uart_rx_valid  output  1  byte held and unread.
REQ-013 SHALL have port uart_rx_busy  output  1  high in any state other than IDLE.
REQ-014 SHALL have ports parity_err_o, frame_err_o, overrun_o  output  1 each  sticky error flags.

Function
REQ-015 uart_rxd SHALL pass a 2-flop synchronizer; rxd_s is the synchronized value, and all FSM decisions SHALL use rxd_s only.
REQ-016 Bit-period register P SHALL reset to (CLK_FREQ/BAUD_RATE)-1 truncated to 16 bits; a write takes effect at the next counter reload, never mid-count; P<3 is unsupported.
REQ-017 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-018 IDLE: once rxd_s has been high for at least one cycle since entry (armed), rxd_s==0 SHALL load counter with H=P>>1 and enter START.
REQ-019 START: counter decrements to 0; at 0, rxd_s==0 -> load P, bit_index=0, enter DATA; rxd_s==1 -> false start, return to IDLE with no output or flag change.
REQ-020 DATA: at each counter==0, rxd_s SHALL be shifted in LSB-first, counter reloaded with P, bit_index incremented; after the 8th sample enter PARITY.
REQ-021 PARITY: at counter==0 sample rxd_s; mismatch with expected parity SHALL set parity_err_o; reload P; enter STOP.
REQ-022 STOP: at counter==0 sample rxd_s; 0 SHALL set frame_err_o; then commit the byte and enter IDLE disarmed.
REQ-023 With rxd_s falling seen in IDLE at cycle t, samples SHALL occur at t+1+H+k(P+1), k=0 start, 1-8 data, 9 parity, 10 stop; uart_rx_valid SHALL rise at t+2+H+10(P+1).
REQ-024 Commit: uart_rx_data updated and uart_rx_valid set even on parity or framing error.
REQ-025 Commit while uart_rx_valid already high SHALL set overrun_o and overwrite uart_rx_data.
REQ-026 rx_read_i SHALL clear uart_rx_valid next cycle; commit and rx_read_i in the same cycle -> valid stays 1, overrun_o not set.
REQ-027 clear_err_i SHALL clear all three error flags next cycle; a same-cycle set event SHALL win.
REQ-028 The counter SHALL be 16 bits unsigned, and no arithmetic SHALL wrap below 0.

Reset
REQ-029 On rst: state IDLE disarmed, synchronizer flops 1, counter 0, bit_index 0, uart_rx_data 0x00, uart_rx_valid 0, uart_rx_busy 0, all error flags 0, P default.
REQ-030 rst mid-frame SHALL abort the frame with no commit; reception restarts only after the line is seen high.

Structure
REQ-031 Package uart_pkg SHALL hold the uart_rx_state_t enum and a default-bit-period function of CLK_FREQ and BAUD_RATE, shared with the transmitter.
REQ-032 The synchronizer SHALL be a sub-module uart_sync_2ff; everything else stays in uart_rx.

Verification (P=433, H=216 unless stated)
REQ-033 Loopback from transmitter, 0xA5, parity_type_i=0 -> uart_rx_data=0xA5, valid at t+2+216+4340, no flags.
REQ-034 0x3C sent with inverted parity bit -> data 0x3C, valid=1, parity_err_o=1; clear_err_i -> 0.
REQ-035 Stop bit driven 0, then line held low 2000 cycles -> frame_err_o=1; no second frame until the line returns high.
REQ-036 100-cycle low glitch in idle -> returns to IDLE, valid 0, no flags.
REQ-037 Two frames 0x11, 0x22 without rx_read_i -> data 0x22, overrun_o=1; repeat with rx_read_i on the commit cycle -> overrun_o=0.
REQ-038 bit_period_i=3 written, 0xFF sent at 4 cycles/bit -> data 0xFF; rst asserted at data bit 4 -> outputs at reset values, no commit.
